ticket_ram_ctrl: RTL and testbench

TICKET_RAM_CTRL -- requirements
Module: ticket_ram_ctrl

---
 rtl/ticket_ram_ctrl_pkg.sv | 54 +++++
 rtl/ticket_ram_ctrl_if.sv | 23 ++
 rtl/ticket_ram_ctrl.sv | 154 +++++++++++++++
 tb/tb_ticket_ram_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ticket_ram_ctrl_pkg.sv
// Shared constants for the ticket RAM controller: command/op/error codes and the ticket record layout.
package ticket_pkg;

  localparam int REC_W     = 65;
  localparam int PAYLOAD_W = 59;

  localparam logic [2:0] OP_IDLE     = 3'b000;
  localparam logic [2:0] OP_BUY      = 3'b001;
  localparam logic [2:0] OP_QUERY    = 3'b010;
  localparam logic [2:0] OP_CHANGE   = 3'b011;
  localparam logic [2:0] OP_DELETE   = 3'b100;
  localparam logic [2:0] OP_READ_IDX = 3'b101;
  localparam logic [2:0] OP_CLEAR    = 3'b111;

  localparam logic [2:0] CMD_NOP        = 3'b000;
  localparam logic [2:0] CMD_BUY        = 3'b001;
  localparam logic [2:0] CMD_QUERY_ID   = 3'b010;
  localparam logic [2:0] CMD_REFUND     = 3'b011;
  localparam logic [2:0] CMD_READ_INDEX = 3'b101;
  localparam logic [2:0] CMD_CLEAR      = 3'b111;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_RAM     = 2'b01;
  localparam logic [1:0] ERR_REFUND  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam int ID_HI      = 64;
  localparam int ID_LO      = 59;
  localparam int SESSION_HI = 53;
  localparam int SESSION_LO = 39;
  localparam int STATE_HI   = 18;
  localparam int STATE_LO   = 17;
  localparam int SEAT_HI    = 16;
  localparam int SEAT_LO    = 7;
  localparam int VIP_BIT    = 0;

  localparam logic [1:0] TKT_UNUSED   = 2'b00;
  localparam logic [1:0] TKT_USED     = 2'b01;
  localparam logic [1:0] TKT_REFUNDED = 2'b10;

  function automatic logic cmd_valid(input logic [2:0] cmd);
    return cmd inside {CMD_BUY, CMD_QUERY_ID, CMD_REFUND, CMD_READ_INDEX, CMD_CLEAR};
  endfunction

  // Write-back image for a refund: state forced to refunded, id field left to the RAM.
  function automatic logic [REC_W-1:0] refund_record(input logic [REC_W-1:0] rec);
    logic [REC_W-1:0] r;
    r = rec;
    r[ID_HI:ID_LO] = '0;
    r[STATE_HI:STATE_LO] = TKT_REFUNDED;
    return r;
  endfunction

endpackage

// File: rtl/ticket_ram_ctrl_if.sv
// RAM-side bus of the ticket controller; master = controller, slave = RAM.
interface ticket_ram_ctrl_if #(
  parameter int DATA_WIDTH = 65
);
  logic [2:0]            op_o;
  logic [5:0]            ram_id_o;
  logic [31:0]           ram_index_o;
  logic [DATA_WIDTH-1:0] ram_data_o;
  logic                  ram_over_i;
  logic                  ram_wrong_i;
  logic [5:0]            ram_id_i;
  logic [DATA_WIDTH-1:0] ram_data_i;

  modport master (
    output op_o, ram_id_o, ram_index_o, ram_data_o,
    input  ram_over_i, ram_wrong_i, ram_id_i, ram_data_i
  );

  modport slave (
    input  op_o, ram_id_o, ram_index_o, ram_data_o,
    output ram_over_i, ram_wrong_i, ram_id_i, ram_data_i
  );
endinterface

// File: rtl/ticket_ram_ctrl.sv
// Ticket command sequencer driving a handshaked ticket RAM (issue / release on ram_over_i).
// Optional per-operation watchdog enabled by defining TICKET_RAM_CTRL_TIMEOUT_EN.
module ticket_ram_ctrl
  import ticket_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int DATA_WIDTH     = 65
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic [2:0]            cmd_i,
  input  logic [5:0]            tkt_id_i,
  input  logic [31:0]           tkt_index_i,
  input  logic [DATA_WIDTH-1:0] tkt_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            err_o,
  output logic [5:0]            result_id_o,
  output logic [DATA_WIDTH-1:0] result_data_o,
  ticket_ram_ctrl_if.master     ram
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_RELEASE = 3'd2;
  localparam logic [2:0] ST_CHECK   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]            state_reg;
  logic [2:0]            cmd_reg;
  logic [2:0]            op_reg;
  logic [5:0]            ram_id_reg;
  logic [31:0]           ram_index_reg;
  logic [DATA_WIDTH-1:0] ram_data_reg;
  logic [1:0]            err_reg;
  logic [5:0]            result_id_reg;
  logic [DATA_WIDTH-1:0] result_data_reg;
  logic                  refund_pend_reg;
  logic                  tmo_hit;
  logic                  unused_bits;

  assign unused_bits = ^tkt_data_i[DATA_WIDTH-1:PAYLOAD_W];

`ifdef TICKET_RAM_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_reg;

  // Counts every cycle spent waiting on the RAM, issue and release alike.
  always_ff @(posedge clk) begin
    if (rst || !(state_reg == ST_ISSUE || state_reg == ST_RELEASE)) begin
      tmo_cnt_reg <= '0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end

  assign tmo_hit = (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES == 0);
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      cmd_reg         <= CMD_NOP;
      op_reg          <= OP_IDLE;
      ram_id_reg      <= '0;
      ram_index_reg   <= '0;
      ram_data_reg    <= '0;
      err_reg         <= ERR_OK;
      result_id_reg   <= '0;
      result_data_reg <= '0;
      refund_pend_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_i && cmd_valid(cmd_i)) begin
            cmd_reg         <= cmd_i;
            op_reg          <= (cmd_i == CMD_REFUND) ? OP_QUERY : cmd_i;
            ram_id_reg      <= tkt_id_i;
            ram_index_reg   <= tkt_index_i;
            ram_data_reg    <= (cmd_i == CMD_BUY) ?
                               {{(DATA_WIDTH-PAYLOAD_W){1'b0}}, tkt_data_i[PAYLOAD_W-1:0]} : '0;
            err_reg         <= ERR_OK;
            result_id_reg   <= '0;
            result_data_reg <= '0;
            refund_pend_reg <= (cmd_i == CMD_REFUND);
            state_reg       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (ram.ram_over_i) begin
            if (cmd_reg == CMD_BUY || cmd_reg == CMD_READ_INDEX) begin
              result_id_reg <= ram.ram_id_i;
            end
            if (op_reg == OP_QUERY || op_reg == OP_READ_IDX) begin
              result_data_reg <= ram.ram_data_i;
            end
            // Clear completes regardless of the wrong flag.
            if (cmd_reg != CMD_CLEAR && ram.ram_wrong_i) begin
              err_reg         <= ERR_RAM;
              refund_pend_reg <= 1'b0;
            end
            state_reg <= ST_RELEASE;
          end else if (tmo_hit) begin
            err_reg   <= ERR_TIMEOUT;
            state_reg <= ST_DONE;
          end
        end
        ST_RELEASE: begin
          if (!ram.ram_over_i) begin
            state_reg <= refund_pend_reg ? ST_CHECK : ST_DONE;
          end else if (tmo_hit) begin
            err_reg   <= ERR_TIMEOUT;
            state_reg <= ST_DONE;
          end
        end
        ST_CHECK: begin
          refund_pend_reg <= 1'b0;
          if (result_data_reg[STATE_HI:STATE_LO] != TKT_UNUSED) begin
            err_reg   <= ERR_REFUND;
            state_reg <= ST_DONE;
          end else begin
            op_reg       <= OP_CHANGE;
            ram_data_reg <= refund_record(result_data_reg);
            state_reg    <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o        = (state_reg == ST_ISSUE) || (state_reg == ST_RELEASE) ||
                         (state_reg == ST_CHECK);
  assign done_o        = (state_reg == ST_DONE);
  assign err_o         = err_reg;
  assign result_id_o   = result_id_reg;
  assign result_data_o = result_data_reg;

  assign ram.op_o        = (state_reg == ST_ISSUE) ? op_reg : OP_IDLE;
  assign ram.ram_id_o    = ram_id_reg;
  assign ram.ram_index_o = ram_index_reg;
  assign ram.ram_data_o  = ram_data_reg;

endmodule

// File: tb/tb_ticket_ram_ctrl.sv
// Directed bench for ticket_ram_ctrl with a behavioural handshaking RAM responder.
module tb_ticket_ram_ctrl;
  import ticket_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic [2:0]  cmd_i;
  logic [5:0]  tkt_id_i;
  logic [31:0] tkt_index_i;
  logic [64:0] tkt_data_i;
  logic        busy_o;
  logic        done_o;
  logic [1:0]  err_o;
  logic [5:0]  result_id_o;
  logic [64:0] result_data_o;

  ticket_ram_ctrl_if #(.DATA_WIDTH(65)) ram ();

  ticket_ram_ctrl #(.TIMEOUT_CYCLES(16), .DATA_WIDTH(65)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .cmd_i        (cmd_i),
    .tkt_id_i     (tkt_id_i),
    .tkt_index_i  (tkt_index_i),
    .tkt_data_i   (tkt_data_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .result_id_o  (result_id_o),
    .result_data_o(result_data_o),
    .ram          (ram)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RAM responder: raises over lat_cfg cycles after an op appears, drops it once op returns to idle.
  int          lat_cfg   = 2;
  logic        wrong_cfg = 1'b0;
  logic        never_cfg = 1'b0;
  logic [5:0]  rid_cfg   = 6'd0;
  logic [64:0] rdata_cfg = 65'd0;
  int          wait_cnt;

  always @(posedge clk) begin
    if (rst) begin
      ram.ram_over_i  <= 1'b0;
      ram.ram_wrong_i <= 1'b0;
      ram.ram_id_i    <= 6'd0;
      ram.ram_data_i  <= 65'd0;
      wait_cnt        <= 0;
    end else if (ram.op_o != 3'b000) begin
      if (!ram.ram_over_i && !never_cfg) begin
        if (wait_cnt >= lat_cfg) begin
          ram.ram_over_i  <= 1'b1;
          ram.ram_wrong_i <= wrong_cfg;
          ram.ram_id_i    <= rid_cfg;
          ram.ram_data_i  <= rdata_cfg;
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end
    end else begin
      ram.ram_over_i  <= 1'b0;
      ram.ram_wrong_i <= 1'b0;
      wait_cnt        <= 0;
    end
  end

  logic [2:0]  prev_op;
  logic [2:0]  op_log[$];
  logic [64:0] wdata_log[$];
  logic [5:0]  id_log[$];

  always @(posedge clk) begin
    if (ram.op_o != 3'b000 && prev_op == 3'b000) begin
      op_log.push_back(ram.op_o);
      wdata_log.push_back(ram.ram_data_o);
      id_log.push_back(ram.ram_id_o);
    end
    prev_op <= ram.op_o;
  end

  logic [1:0]  done_err;
  logic [5:0]  done_id;
  logic [64:0] done_data;
  logic        done_busy;
  logic [2:0]  done_op;

  task automatic send_cmd(input logic [2:0] c, input logic [5:0] id, input logic [31:0] idx,
                          input logic [64:0] d);
    @(negedge clk);
    req_i = 1'b1; cmd_i = c; tkt_id_i = id; tkt_index_i = idx; tkt_data_i = d;
    @(negedge clk);
    req_i = 1'b0; cmd_i = 3'b000;
  endtask

  task automatic run_txn(input string tag, input logic [2:0] c, input logic [5:0] id,
                         input logic [31:0] idx, input logic [64:0] d);
    bit seen;
    op_log.delete(); wdata_log.delete(); id_log.delete();
    send_cmd(c, id, idx, d);
    check({tag, "_busy"}, 65'(busy_o), 65'd1);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_done"}, 65'(seen), 65'd1);
    done_err = err_o; done_id = result_id_o; done_data = result_data_o;
    done_busy = busy_o; done_op = ram.op_o;
    $display("txn %s cmd=%0d err=%0d id=%0d data=%0h ops=%0d", tag, c, done_err, done_id,
             done_data, op_log.size());
    check({tag, "_busy_at_done"}, 65'(done_busy), 65'd0);
    @(negedge clk);
    check({tag, "_pulse"}, 65'(done_o), 65'd0);
  endtask

  localparam logic [64:0] REC_FREE  = {6'd5, 59'h765_4321_0001_1F07};
  localparam logic [64:0] REC_FREEW = {6'd0, 59'h765_4321_0005_1F07};
  localparam logic [64:0] REC_USED  = {6'd5, 59'h765_4321_0002_1F07};
  localparam logic [64:0] REC_IDX   = 65'h1_2345_6789_ABCD_EF01;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_wait;
    bit seen;
    rst = 1'b1; req_i = 1'b0; cmd_i = 3'b000; tkt_id_i = 6'd0; tkt_index_i = 32'd0;
    tkt_data_i = 65'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", 65'(busy_o), 65'd0);
    check("rst_done", 65'(done_o), 65'd0);
    check("rst_err", 65'(err_o), 65'd0);
    check("rst_op", 65'(ram.op_o), 65'd0);
    check("rst_rid", 65'(result_id_o), 65'd0);
    check("rst_rdata", result_data_o, 65'd0);
    check("rst_ram_id", 65'(ram.ram_id_o), 65'd0);
    check("rst_ram_idx", 65'(ram.ram_index_o), 65'd0);
    check("rst_ram_data", ram.ram_data_o, 65'd0);
    rst = 1'b0;

    // Buy: upper id bits of the request must not reach the RAM.
    rid_cfg = 6'd1; rdata_cfg = 65'd0;
    run_txn("buy", CMD_BUY, 6'd0, 32'd0, {6'h3F, 59'h1234});
    check("buy_err", 65'(done_err), 65'd0);
    check("buy_id", 65'(done_id), 65'd1);
    check("buy_nops", 65'(op_log.size()), 65'd1);
    check("buy_op", 65'(op_log[0]), 65'd1);
    check("buy_wdata", wdata_log[0], {6'd0, 59'h1234});

    rdata_cfg = REC_FREE;
    run_txn("refund_free", CMD_REFUND, 6'd5, 32'd0, 65'd0);
    check("rf_err", 65'(done_err), 65'd0);
    check("rf_nops", 65'(op_log.size()), 65'd2);
    check("rf_op0", 65'(op_log[0]), 65'd2);
    check("rf_op1", 65'(op_log[1]), 65'd3);
    check("rf_wdata", wdata_log[1], REC_FREEW);
    check("rf_id", 65'(id_log[1]), 65'd5);
    check("rf_rdata", done_data, REC_FREE);

    rdata_cfg = REC_USED;
    run_txn("refund_used", CMD_REFUND, 6'd5, 32'd0, 65'd0);
    check("ru_err", 65'(done_err), 65'd2);
    check("ru_nops", 65'(op_log.size()), 65'd1);
    check("ru_op0", 65'(op_log[0]), 65'd2);
    check("ru_err_held", 65'(err_o), 65'd2);

    wrong_cfg = 1'b1;
    run_txn("query_missing", CMD_QUERY_ID, 6'd9, 32'd0, 65'd0);
    check("qm_err", 65'(done_err), 65'd1);
    check("qm_op_idle", 65'(done_op), 65'd0);
    check("qm_id", 65'(id_log[0]), 65'd9);

    run_txn("clear", CMD_CLEAR, 6'd0, 32'd0, 65'd0);
    check("clr_err", 65'(done_err), 65'd0);
    check("clr_op", 65'(op_log[0]), 65'd7);

    rdata_cfg = REC_FREE;
    run_txn("refund_wrong", CMD_REFUND, 6'd5, 32'd0, 65'd0);
    check("rw_err", 65'(done_err), 65'd1);
    check("rw_nops", 65'(op_log.size()), 65'd1);
    wrong_cfg = 1'b0;

    rid_cfg = 6'd12; rdata_cfg = REC_IDX;
    run_txn("read_index", CMD_READ_INDEX, 6'd0, 32'd3, 65'd0);
    check("ri_err", 65'(done_err), 65'd0);
    check("ri_id", 65'(done_id), 65'd12);
    check("ri_data", done_data, REC_IDX);
    check("ri_op", 65'(op_log[0]), 65'd5);
    check("ri_index", 65'(ram.ram_index_o), 65'd3);

    // Reserved commands are dropped.
    op_log.delete();
    send_cmd(3'b100, 6'd1, 32'd0, 65'd0);
    check("ign100_busy", 65'(busy_o), 65'd0);
    send_cmd(3'b110, 6'd1, 32'd0, 65'd0);
    check("ign110_busy", 65'(busy_o), 65'd0);
    send_cmd(3'b000, 6'd1, 32'd0, 65'd0);
    check("ign000_busy", 65'(busy_o), 65'd0);
    repeat (4) @(negedge clk);
    check("ign_nops", 65'(op_log.size()), 65'd0);
    $display("txn ignored_cmds ops=%0d", op_log.size());

    // A request while busy is neither taken nor queued.
    lat_cfg = 6; rid_cfg = 6'd2;
    op_log.delete();
    send_cmd(CMD_BUY, 6'd0, 32'd0, 65'd7);
    req_i = 1'b1; cmd_i = CMD_QUERY_ID; tkt_id_i = 6'd7;
    repeat (2) @(negedge clk);
    req_i = 1'b0; cmd_i = 3'b000;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("bz_done", 65'(seen), 65'd1);
    check("bz_id", 65'(result_id_o), 65'd2);
    repeat (5) @(negedge clk);
    check("bz_idle", 65'(busy_o), 65'd0);
    check("bz_nops", 65'(op_log.size()), 65'd1);
    $display("txn busy_ignore ops=%0d", op_log.size());
    lat_cfg = 2;

    // Reset landing on the refund check cycle must suppress the write phase.
    rdata_cfg = REC_FREE;
    op_log.delete();
    send_cmd(CMD_REFUND, 6'd5, 32'd0, 65'd0);
    for (int i = 0; i < 50 && !ram.ram_over_i; i++) @(negedge clk);
    for (int i = 0; i < 50 && !(busy_o && ram.op_o == 3'b000 && !ram.ram_over_i); i++)
      @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rc_op", 65'(ram.op_o), 65'd0);
    check("rc_busy", 65'(busy_o), 65'd0);
    check("rc_done", 65'(done_o), 65'd0);
    check("rc_err", 65'(err_o), 65'd0);
    check("rc_rdata", result_data_o, 65'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("rc_nops", 65'(op_log.size()), 65'd1);
    check("rc_idle", 65'(busy_o), 65'd0);
    $display("txn reset_in_check ops=%0d", op_log.size());

    // RAM never answers.
    never_cfg = 1'b1;
    op_log.delete();
    send_cmd(CMD_QUERY_ID, 6'd9, 32'd0, 65'd0);
    n_wait = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      if (ram.op_o != 3'b000) n_wait++;
      @(negedge clk);
    end
`ifdef TICKET_RAM_CTRL_TIMEOUT_EN
    check("tmo_done", 65'(seen), 65'd1);
    check("tmo_cycles", 65'(n_wait), 65'd16);
    check("tmo_err", 65'(err_o), 65'd3);
    check("tmo_op", 65'(ram.op_o), 65'd0);
`else
    check("wait_done", 65'(seen), 65'd0);
    check("wait_busy", 65'(busy_o), 65'd1);
    check("wait_op", 65'(ram.op_o), 65'd2);
    check("wait_err", 65'(err_o), 65'd0);
`endif
    $display("txn no_answer done=%0d wait=%0d err=%0d", seen, n_wait, err_o);
    rst = 1'b1;
    never_cfg = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("end_idle", 65'(busy_o), 65'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
